// File: rtl/color_pkg.sv
// Shared types and constants for the obstacle-row colour generator.
package color_pkg;

  typedef logic [2:0] color_t;

  localparam color_t NONE   = 3'd0;
  localparam color_t PURPLE = 3'd1;
  localparam color_t ORANGE = 3'd2;
  localparam color_t YELLOW = 3'd3;
  localparam color_t BLUE   = 3'd4;
  localparam color_t RED    = 3'd5;
  localparam color_t GREEN  = 3'd6;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t GEN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Maximal-length Fibonacci tap masks; bit k-1 set for tap k.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/color_row_generator_if.sv
// Request/row handshake and seed-load bundle between game controller and generator.
interface color_row_generator_if #(
  parameter int unsigned LANES  = 5,
  parameter int unsigned LFSR_W = 16
) ();

  logic                req;
  logic                busy;
  logic                row_valid;
  logic                row_ack;
  logic [LANES*3-1:0]  row_colors;
  logic                seed_wr;
  logic [LFSR_W-1:0]   seed_data;

  modport master (
    output req, row_ack, seed_wr, seed_data,
    input  busy, row_valid, row_colors
  );

  modport slave (
    input  req, row_ack, seed_wr, seed_data,
    output busy, row_valid, row_colors
  );

endinterface

// File: rtl/lfsr_core.sv
// Free-running Fibonacci left-shift LFSR with seed load; a zero seed is replaced by
// SEED so the register can never lock up in the all-zero state.
module lfsr_core
  import color_pkg::*;
#(
  parameter int unsigned LFSR_W = 16,
  parameter logic [31:0] SEED   = 32'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_wr_i,
  input  logic [LFSR_W-1:0] seed_data_i,
  output logic [2:0]        draw_o
);

  localparam logic [LFSR_W-1:0] Taps  = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] SeedW = SEED[LFSR_W-1:0];

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[LFSR_W-2:0], ^(state_q & Taps)};
    if (seed_wr_i) begin
      state_d = (seed_data_i == '0) ? SeedW : seed_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SeedW;
    end else begin
      state_q <= state_d;
    end
  end

  assign draw_o = state_q[2:0];

endmodule

// File: rtl/color_row_generator.sv
// Builds a row of LANES colour codes from LFSR draws by rejection sampling with a retry bound.
// Define NO_ADJACENT_REPEAT_EN to force neighbouring lanes to differ.
module color_row_generator
  import color_pkg::*;
#(
  parameter int unsigned LANES      = 5,
  parameter int unsigned NUM_COLORS = 6,
  parameter int unsigned LFSR_W     = 16,
  parameter logic [31:0] SEED       = 32'hACE1,
  parameter int unsigned MAX_RETRY  = 7
) (
  input logic                  clk,
  input logic                  rst,
  color_row_generator_if.slave bus
);

  localparam int unsigned       LaneW     = $clog2(LANES + 1);
  localparam int unsigned       RetryW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam color_t            NumColors = color_t'(NUM_COLORS);
  localparam logic [LaneW-1:0]  LastLane  = LaneW'(LANES - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  color_t [LANES-1:0] shadow_q, shadow_d;
  logic [LANES*3-1:0] row_colors_q, row_colors_d;
  color_t             cand, pick;
  logic               cand_ok, accept;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .seed_wr_i   (bus.seed_wr),
    .seed_data_i (bus.seed_data),
    .draw_o      (cand)
  );

  function automatic color_t forced_color(input color_t c);
    return (c % NumColors) + 3'd1;
  endfunction

`ifdef NO_ADJACENT_REPEAT_EN
  color_t prev;

  always_comb begin
    prev = NONE;
    for (int unsigned i = 0; i + 1 < LANES; i++) begin
      if (lane_q == LaneW'(i + 1)) prev = shadow_q[i];
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    retry_d      = retry_q;
    shadow_d     = shadow_q;
    row_colors_d = row_colors_q;
    accept       = 1'b0;
    pick         = cand;
    cand_ok      = (cand != NONE) && (cand <= NumColors);
`ifdef NO_ADJACENT_REPEAT_EN
    if ((lane_q != '0) && (cand == prev)) cand_ok = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = GEN;
          lane_d  = '0;
          retry_d = '0;
        end
      end
      GEN: begin
        if (cand_ok) begin
          accept = 1'b1;
        end else if (retry_q == RetryMax) begin
          accept = 1'b1;
          pick   = forced_color(cand);
`ifdef NO_ADJACENT_REPEAT_EN
          if ((lane_q != '0) && (pick == prev)) begin
            pick = (pick == NumColors) ? PURPLE : pick + 3'd1;
          end
`endif
        end else begin
          retry_d = retry_q + RetryW'(1);
        end

        if (accept) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == LaneW'(i)) shadow_d[i] = pick;
          end
          lane_d  = lane_q + LaneW'(1);
          retry_d = '0;
          // Publish the whole row at once, final lane included, so no partial row is visible.
          if (lane_q == LastLane) begin
            state_d      = DONE;
            row_colors_d = shadow_d;
          end
        end
      end
      DONE: begin
        if (bus.row_ack) begin
          state_d = bus.req ? GEN : IDLE;
          lane_d  = '0;
          retry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      retry_q      <= '0;
      shadow_q     <= '0;
      row_colors_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      retry_q      <= retry_d;
      shadow_q     <= shadow_d;
      row_colors_q <= row_colors_d;
    end
  end

  assign bus.busy       = (state_q == GEN);
  assign bus.row_valid  = (state_q == DONE);
  assign bus.row_colors = row_colors_q;

endmodule

// File: doc/color_row_generator.md
Name: color_row_generator

Overview:
- Parameterised successor to the game's free-running colour randomiser.
- An LFSR produces a row of LANES colour codes on request, with uniform distribution over NUM_COLORS colours by rejection sampling.
- It has a req/valid/ack handshake, runtime reseeding, and a retry bound.
- Sits between the game controller (which requests a new obstacle row) and the row renderer (which consumes it).

Parameters:
- LANES, 5: colour lanes per row, range 1..16.
- NUM_COLORS, 6: colour codes in use, 1..NUM_COLORS, range 2..7. Code 0 is reserved as "none".
- LFSR_W, 16: LFSR width, one of 8/16/32.
- SEED, 16'hACE1: reset and zero-substitute seed, truncated to LFSR_W. Must be non-zero.
- MAX_RETRY, 7: rejected draws per lane before the forced mapping applies.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- req, in, 1: request a new row.
- busy, out, 1: high while generating.
- row_valid, out, 1: row_colors holds a completed row.
- row_ack, in, 1: consumer accepts the row.
- row_colors, out, LANES*3: lane i is at [3i+2:3i].
- seed_wr, in, 1: load seed_data into the LFSR.
- seed_data, in, LFSR_W: new seed.

Behaviour:
- Reset (rst sampled high on clk):
  - lfsr = SEED, state = IDLE, lane index and retry count = 0.
  - row_colors = 0, row_valid = 0, busy = 0.
  - Reset mid-GEN abandons the partial row; row_colors clears.
- LFSR:
  - Fibonacci, left shift, advances every cycle in every state (free-running entropy).
  - Maximal taps: 8:{8,6,5,4}; 16:{16,14,13,11}; 32:{32,22,2,1}.
  - Priority: rst > seed_wr > advance.
  - seed_wr loads seed_data, or SEED if seed_data == 0. Generation in progress continues from the new state.
- Candidate each cycle = lfsr[2:0].
- FSM IDLE:
  - busy = 0.
  - req -> GEN next cycle, with lane = 0 and retry = 0.
- FSM GEN:
  - busy = 1; req is ignored.
  - Candidate in 1..NUM_COLORS -> accept: write shadow[lane], lane++, retry = 0.
  - Otherwise retry++.
  - If retry == MAX_RETRY: forced accept with (candidate mod NUM_COLORS) + 1.
  - Accept of lane LANES-1 -> DONE next cycle. In the same edge, row_colors <= shadow, including the final lane.
- FSM DONE:
  - row_valid = 1, busy = 0. row_colors is stable until ack.
  - row_ack -> IDLE, row_valid falls next cycle.
  - row_ack and req together -> GEN directly (back-to-back rows).
  - req without row_ack is ignored.
  - row_ack outside DONE is ignored.
- Latency:
  - req accepted at edge t gives row_valid at edge t+LANES+1 with no rejects.
  - Worst case is t+LANES*(MAX_RETRY+1)+1.
- row_colors only changes at DONE entry or reset. Never expose a partial row.
- Width rules:
  - lane counter is clog2(LANES+1) bits.
  - retry counter is clog2(MAX_RETRY+1) bits.
  - Modulo is on a 3-bit value; a combinational constant-divisor table is acceptable.

Optional Feature:
- NO_ADJACENT_REPEAT_EN:
  - When defined, in GEN a candidate equal to shadow[lane-1] (lane > 0) is treated as a reject.
  - A forced accept that equals the previous colour is incremented: wrap NUM_COLORS -> 1.
  - Result: adjacent lanes always differ.
- When undefined, adjacent repeats are allowed and there is no extra logic.

Decomposition:
- Package color_pkg holds:
  - color_t (3-bit) and constants NONE=0, PURPLE=1, ORANGE=2, YELLOW=3, BLUE=4, RED=5, GREEN=6.
  - The FSM state enum {IDLE, GEN, DONE}.
  - Function lfsr_taps(width), returning the tap mask.
- One natural sub-module: lfsr_core, holding the parameterised LFSR with seed load and zero substitution.
- Draw/accept logic and the FSM stay in color_row_generator.

Test Plan:
- Reset behaviour:
  - Stimulus: rst high 2 cycles, then low, with req held low.
  - Required: row_colors == 0, row_valid == 0, busy == 0.
  - Required: internal lfsr == 16'hACE1 on the cycle after rst falls.
- Single request:
  - Stimulus: req pulse in IDLE.
  - Required: busy high from the next cycle.
  - Required: row_valid rises 6..41 cycles later (LANES=5, MAX_RETRY=7).
  - Required: every lane in 1..6; row_colors stable until row_ack; row_valid low 1 cycle after ack.
- Zero-seed substitution:
  - Stimulus: seed_wr with seed_data = 0, then req.
  - Required: lfsr == 16'hACE1 next cycle; the row matches a reference model seeded with 16'hACE1.
- Back-to-back and ignored requests:
  - Stimulus: req during GEN, req alone in DONE, then req+row_ack in DONE.
  - Required: the first two are ignored; the third gives busy high next cycle with no IDLE gap.
  - Required: 1000 such rows all valid.
- Forced-accept path:
  - Stimulus: NUM_COLORS=2, MAX_RETRY=1, 10000 rows.
  - Required: all lanes in {1,2}; no lane takes more than 2 GEN cycles.
  - Required: under NO_ADJACENT_REPEAT_EN, no equal adjacent lanes.
- Reset mid-operation:
  - Stimulus: rst asserted on the 3rd GEN cycle.
  - Required: next cycle IDLE, row_colors == 0, row_valid == 0.
  - Required: a subsequent req completes normally.
